// File: rtl/fifo_pkg.sv
// Shared FIFO types plus the push-side arbiter state encoding and index helper.
package fifo_pkg;

    localparam int unsigned DATA_W = 8;

    typedef logic [DATA_W-1:0] data_t;

    typedef enum logic {
        NO_PUSH = 1'b0,
        PUSH    = 1'b1
    } push_e_t;

    typedef enum logic {
        IDLE = 1'b0,
        OWN  = 1'b1
    } arb_state_e_t;

    // Index of the set bit in a one-hot vector; 0 for an all-zero vector.
    function automatic int unsigned onehot_to_idx(input logic [31:0] oh);
        int unsigned idx;
        idx = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if (oh[i]) idx = i;
        end
        return idx;
    endfunction

endpackage

// File: rtl/fifo_rr_pick.sv
// Round-robin picker: first set request at or after start_i, ascending with wrap.
module fifo_rr_pick
    import fifo_pkg::*;
#(
    parameter int unsigned N_REQ = 4
) (
    input  logic [N_REQ-1:0]         req_i,
    input  logic [$clog2(N_REQ)-1:0] start_i,
    output logic                     valid_o,
    output logic [$clog2(N_REQ)-1:0] idx_o
);
    localparam int unsigned IDX_W = $clog2(N_REQ);

    logic [IDX_W-1:0] cand;

    // Walk the scan order backwards so the earliest candidate is written last.
    always_comb begin
        valid_o = 1'b0;
        idx_o   = '0;
        cand    = '0;
        for (int i = int'(N_REQ) - 1; i >= 0; i--) begin
            cand = IDX_W'((32'(start_i) + 32'(i)) % N_REQ);
            if (req_i[cand]) begin
                valid_o = 1'b1;
                idx_o   = cand;
            end
        end
    end

endmodule

// File: rtl/fifo_push_arbiter.sv
// Shares one FIFO write port among N_REQ producers: round-robin grants with
// a bounded burst per grant and zero-bubble handoff between owners.
module fifo_push_arbiter
    import fifo_pkg::*;
#(
    parameter int unsigned N_REQ     = 4,
    parameter int unsigned MAX_BURST = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req_i,
    input  data_t            data_i [N_REQ],
    output logic [N_REQ-1:0] ack_o,
    output logic [N_REQ-1:0] grant_o,
    output push_e_t          push,
    output data_t            data_in,
    input  logic             full
);
    localparam int unsigned IDX_W = $clog2(N_REQ);
    localparam int unsigned CNT_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;

    arb_state_e_t     state_q;
    logic [N_REQ-1:0] grant_q;
    logic [CNT_W-1:0] burst_q;
    logic [IDX_W-1:0] last_q;

    logic [IDX_W-1:0] owner;
    logic [IDX_W-1:0] pick_start;
    logic [IDX_W-1:0] pick_idx;
    logic             pick_valid;
    logic             own;
    logic             push_c;
    logic             last_word;
    logic             exit_c;
    logic [N_REQ-1:0] masked_req;
    logic [N_REQ-1:0] pick_req;

    function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] idx);
        return (idx == IDX_W'(N_REQ - 1)) ? '0 : IDX_W'(idx + 1'b1);
    endfunction

    // An owner that just spent its last burst word steps aside unless nobody else wants the port.
    always_comb begin
        owner      = IDX_W'(onehot_to_idx(32'(grant_q)));
        own        = (state_q == OWN);
        push_c     = own && req_i[owner] && !full;
        last_word  = (burst_q == CNT_W'(MAX_BURST - 1));
        exit_c     = own && (!req_i[owner] || (push_c && last_word));
        masked_req = (push_c && last_word) ? (req_i & ~grant_q) : req_i;
        pick_req   = (masked_req != '0) ? masked_req : req_i;
        pick_start = own ? wrap_inc(owner) : wrap_inc(last_q);
    end

    fifo_rr_pick #(
        .N_REQ (N_REQ)
    ) u_pick (
        .req_i   (pick_req),
        .start_i (pick_start),
        .valid_o (pick_valid),
        .idx_o   (pick_idx)
    );

    assign push    = push_c ? PUSH : NO_PUSH;
    assign ack_o   = push_c ? grant_q : '0;
    assign data_in = own ? data_i[owner] : '0;
    assign grant_o = grant_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            grant_q <= '0;
            burst_q <= '0;
            last_q  <= IDX_W'(N_REQ - 1);
        end else begin
            case (state_q)
                IDLE: begin
                    if (pick_valid) begin
                        state_q <= OWN;
                        grant_q <= N_REQ'(1) << pick_idx;
                        burst_q <= '0;
                    end
                end
                OWN: begin
                    if (exit_c) begin
                        last_q  <= owner;
                        burst_q <= '0;
                        if (pick_valid) begin
                            grant_q <= N_REQ'(1) << pick_idx;
                        end else begin
                            state_q <= IDLE;
                            grant_q <= '0;
                        end
                    end else if (push_c) begin
                        burst_q <= burst_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    grant_q <= '0;
                    burst_q <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_push_arbiter.sv
// Bench for fifo_push_arbiter: directed vector table, corner sequences and a random soak
// checked against a behavioural model with a write scoreboard.
module tb_fifo_push_arbiter;
    import fifo_pkg::*;

    localparam int N     = 4;
    localparam int MB    = 4;
    localparam int LIMIT = (N - 1) * MB;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [N-1:0] req_i;
    data_t        data_i [N];
    logic [N-1:0] ack_o;
    logic [N-1:0] grant_o;
    push_e_t      push;
    data_t        data_in;
    logic         full;

    always #5 clk = ~clk;

    fifo_push_arbiter #(
        .N_REQ     (N),
        .MAX_BURST (MB)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .req_i   (req_i),
        .data_i  (data_i),
        .ack_o   (ack_o),
        .grant_o (grant_o),
        .push    (push),
        .data_in (data_in),
        .full    (full)
    );

    typedef struct {
        int    idx;
        data_t data;
    } wr_t;

    typedef struct {
        logic [N-1:0] req;
        logic         full;
        logic [N-1:0] grant;
        logic         push;
        logic [N-1:0] ack;
        data_t        data;
    } vec_t;

    int    n_checks = 0;
    int    n_fail   = 0;
    wr_t   sb_q[$];
    data_t dval [N];
    int    wait_cnt [N];

    bit m_own;
    int m_owner;
    int m_cnt;
    int m_last;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_own   = 1'b0;
        m_owner = 0;
        m_cnt   = 0;
        m_last  = N - 1;
        sb_q.delete();
        for (int k = 0; k < N; k++) wait_cnt[k] = 0;
    endtask

    function automatic int rr_scan(input logic [N-1:0] r, input int from);
        for (int i = 1; i <= N; i++) begin
            if (r[(from + i) % N]) return (from + i) % N;
        end
        return -1;
    endfunction

    // Compare this cycle's outputs with the model, run the scoreboard, then advance the model.
    task automatic check_cycle();
        logic [N-1:0] eg;
        logic [N-1:0] r;
        logic         mp;
        wr_t          w;
        int           nx;
        int           mx;
        eg = m_own ? (N'(1) << m_owner) : '0;
        mp = m_own && req_i[m_owner] && !full;
        chk("grant", 32'(grant_o), 32'(eg));
        chk("push", 32'(push == PUSH), 32'(mp));
        chk("ack", 32'(ack_o), mp ? 32'(eg) : 32'd0);
        chk("data_in", 32'(data_in), m_own ? 32'(data_i[m_owner]) : 32'd0);
        chk("inv_grant_onehot0", 32'($onehot0(grant_o)), 32'd1);
        chk("inv_ack_onehot0", 32'($onehot0(ack_o)), 32'd1);
        if (push == PUSH) chk("inv_push_full_ack", 32'(!full && (ack_o == grant_o)), 32'd1);
        if (mp) begin
            w.idx  = m_owner;
            w.data = data_i[m_owner];
            sb_q.push_back(w);
        end
        if (push == PUSH) begin
            chk("sb_depth", 32'(sb_q.size()), 32'd1);
            if (sb_q.size() != 0) begin
                w = sb_q.pop_front();
                chk("sb_data", 32'(data_in), 32'(w.data));
                chk("sb_ack", 32'(ack_o), 32'(N'(1) << w.idx));
            end
        end
        mx = 0;
        for (int k = 0; k < N; k++) begin
            if (!req_i[k] || ack_o[k]) wait_cnt[k] = 0;
            else if (push == PUSH) wait_cnt[k]++;
            if (wait_cnt[k] > mx) mx = wait_cnt[k];
        end
        if (push == PUSH) chk("fairness_wait", 32'(mx <= LIMIT), 32'd1);
        if (!m_own) begin
            nx = rr_scan(req_i, m_last);
            if (nx >= 0) begin
                m_own   = 1'b1;
                m_owner = nx;
                m_cnt   = 0;
            end
        end else if (!req_i[m_owner] || (mp && m_cnt == MB - 1)) begin
            r = req_i;
            if (mp && m_cnt == MB - 1 && (req_i & ~(N'(1) << m_owner)) != '0) r[m_owner] = 1'b0;
            m_last = m_owner;
            m_cnt  = 0;
            nx     = rr_scan(r, m_owner);
            if (nx >= 0) m_owner = nx;
            else m_own = 1'b0;
        end else if (mp) begin
            m_cnt++;
        end
    endtask

    task automatic drive_cycle(input logic [N-1:0] r, input logic f);
        @(negedge clk);
        req_i = r;
        full  = f;
        for (int k = 0; k < N; k++) data_i[k] = dval[k];
        #1;
        check_cycle();
    endtask

    // Reset is asserted between edges so the outputs must clear without a clock.
    task automatic apply_reset();
        rst = 1'b1;
        #1;
        chk("rst_grant", 32'(grant_o), 32'd0);
        chk("rst_push", 32'(push == PUSH), 32'd0);
        chk("rst_ack", 32'(ack_o), 32'd0);
        chk("rst_data_in", 32'(data_in), 32'd0);
        repeat (2) @(negedge clk);
        req_i = '0;
        full  = 1'b0;
        rst   = 1'b0;
        model_reset();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t         tbl [12];
        int           acks;
        logic [N-1:0] rq;
        logic [N-1:0] last_ack;
        logic         fl;

        tbl[0]  = '{4'b0001, 1'b0, 4'b0000, 1'b0, 4'b0000, 8'h00};
        tbl[1]  = '{4'b0001, 1'b0, 4'b0001, 1'b1, 4'b0001, 8'hA0};
        tbl[2]  = '{4'b0001, 1'b0, 4'b0001, 1'b1, 4'b0001, 8'hA0};
        tbl[3]  = '{4'b0001, 1'b0, 4'b0001, 1'b1, 4'b0001, 8'hA0};
        tbl[4]  = '{4'b0001, 1'b0, 4'b0001, 1'b1, 4'b0001, 8'hA0};
        tbl[5]  = '{4'b0001, 1'b0, 4'b0001, 1'b1, 4'b0001, 8'hA0};
        tbl[6]  = '{4'b0101, 1'b1, 4'b0001, 1'b0, 4'b0000, 8'hA0};
        tbl[7]  = '{4'b0101, 1'b0, 4'b0001, 1'b1, 4'b0001, 8'hA0};
        tbl[8]  = '{4'b0100, 1'b0, 4'b0001, 1'b0, 4'b0000, 8'hA0};
        tbl[9]  = '{4'b0100, 1'b0, 4'b0100, 1'b1, 4'b0100, 8'hC2};
        tbl[10] = '{4'b0000, 1'b0, 4'b0100, 1'b0, 4'b0000, 8'hC2};
        tbl[11] = '{4'b0000, 1'b0, 4'b0000, 1'b0, 4'b0000, 8'h00};

        dval[0] = 8'hA0;
        dval[1] = 8'hB1;
        dval[2] = 8'hC2;
        dval[3] = 8'hD3;
        req_i = '0;
        full  = 1'b0;
        for (int k = 0; k < N; k++) data_i[k] = dval[k];
        model_reset();
        #2;
        apply_reset();

        for (int i = 0; i < 12; i++) begin
            drive_cycle(tbl[i].req, tbl[i].full);
            chk($sformatf("tbl%0d_grant", i), 32'(grant_o), 32'(tbl[i].grant));
            chk($sformatf("tbl%0d_push", i), 32'(push == PUSH), 32'(tbl[i].push));
            chk($sformatf("tbl%0d_ack", i), 32'(ack_o), 32'(tbl[i].ack));
            chk($sformatf("tbl%0d_data", i), 32'(data_in), 32'(tbl[i].data));
        end

        // All four requesting: bursts of MB in order 0,1,2,3,0 with no idle gap.
        apply_reset();
        drive_cycle(4'b1111, 1'b0);
        chk("rr_idle_latency", 32'(grant_o), 32'd0);
        for (int o = 0; o < 5; o++) begin
            for (int b = 0; b < MB; b++) begin
                drive_cycle(4'b1111, 1'b0);
                chk($sformatf("rr_grant_o%0d_b%0d", o, b), 32'(grant_o), 32'(N'(1) << (o % N)));
                chk($sformatf("rr_push_o%0d_b%0d", o, b), 32'(push == PUSH), 32'd1);
            end
        end

        // Owner 2 stalled by full mid-burst still delivers exactly MB words.
        apply_reset();
        acks = 0;
        drive_cycle(4'b1100, 1'b0);
        for (int i = 0; i < 2; i++) begin
            drive_cycle(4'b1100, 1'b0);
            if (ack_o[2]) acks++;
        end
        for (int i = 0; i < 5; i++) begin
            drive_cycle(4'b1100, 1'b1);
            chk("stall_push", 32'(push == PUSH), 32'd0);
            chk("stall_ack", 32'(ack_o), 32'd0);
            chk("stall_grant", 32'(grant_o), 32'b0100);
        end
        for (int i = 0; i < 20 && grant_o != 4'b1000; i++) begin
            drive_cycle(4'b1100, 1'b0);
            if (ack_o[2]) acks++;
        end
        chk("stall_acks_req2", 32'(acks), 32'(MB));
        chk("stall_handoff_grant", 32'(grant_o), 32'b1000);

        // Owner 1 withdraws after two words; requester 3 takes over next cycle.
        apply_reset();
        acks = 0;
        drive_cycle(4'b1010, 1'b0);
        for (int i = 0; i < 2; i++) begin
            drive_cycle(4'b1010, 1'b0);
            chk("wd_grant1", 32'(grant_o), 32'b0010);
            if (ack_o[1]) acks++;
        end
        drive_cycle(4'b1000, 1'b0);
        chk("wd_no_push", 32'(push == PUSH), 32'd0);
        chk("wd_no_ack", 32'(ack_o), 32'd0);
        drive_cycle(4'b1000, 1'b0);
        chk("wd_grant3", 32'(grant_o), 32'b1000);
        chk("wd_acks_req1", 32'(acks), 32'd2);

        // Reset in the middle of owner 3's burst; requester 0 wins first afterwards.
        apply_reset();
        drive_cycle(4'b1000, 1'b0);
        drive_cycle(4'b1000, 1'b0);
        drive_cycle(4'b1000, 1'b0);
        chk("midrst_owner3", 32'(grant_o), 32'b1000);
        apply_reset();
        drive_cycle(4'b1001, 1'b0);
        chk("midrst_idle_after", 32'(grant_o), 32'd0);
        drive_cycle(4'b1001, 1'b0);
        chk("midrst_first_grant", 32'(grant_o), 32'b0001);

        // Random soak: requesters hold until acked or occasionally withdraw.
        apply_reset();
        rq       = '0;
        last_ack = '0;
        for (int c = 0; c < 10000; c++) begin
            for (int k = 0; k < N; k++) begin
                if (rq[k]) begin
                    if (last_ack[k]) begin
                        dval[k] = dval[k] + 8'd1;
                        if ($urandom_range(3) == 0) rq[k] = 1'b0;
                    end else if ($urandom_range(15) == 0) begin
                        rq[k] = 1'b0;
                    end
                end else if ($urandom_range(2) == 0) begin
                    rq[k] = 1'b1;
                end
            end
            fl = ($urandom_range(3) == 0);
            drive_cycle(rq, fl);
            last_ack = ack_o;
        end
        chk("sb_empty_at_end", 32'(sb_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
